// File: rtl/lopd_norm_shifter.sv
// Normalizing left shifter fed by the leading-one position detector.
// Applies one binary shift stage per cycle and adjusts the biased exponent, clamping to denormal on underflow.
module lopd_norm_shifter #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_EXP  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic [SIZE_LOPD-1:0] i_one_position,
  input  logic                 i_zero_flag,
  input  logic [SIZE_EXP-1:0]  i_exp,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
  output logic [SIZE_EXP-1:0]  o_exp,
  output logic [SIZE_LOPD-1:0] o_shift_amt,
  output logic                 o_zero,
  output logic                 o_underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (SIZE_EXP > SIZE_LOPD) ? SIZE_EXP : SIZE_LOPD;
  localparam logic [SIZE_LOPD-1:0] MAX_POS = SIZE_LOPD'(SIZE_DATA - 1);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [SIZE_DATA-1:0]   data_r;
  logic [SIZE_EXP-1:0]    exp_r;
  logic [SIZE_LOPD-1:0]   shift_amt_r;
  logic [SIZE_LOPD-1:0]   rem_r;
  logic                   zero_r;
  logic                   underflow_r;

  logic [SIZE_LOPD-1:0]   pos_s;
  logic [SIZE_LOPD-1:0]   shamt_s;
  logic [CW-1:0]          shamt_w_s;
  logic [CW-1:0]          exp_w_s;
  logic [SIZE_LOPD-1:0]   shift_eff_s;
  logic [SIZE_EXP-1:0]    exp_adj_s;
  logic                   uf_s;
  logic [SIZE_LOPD-1:0]   step_s;
  logic [SIZE_LOPD-1:0]   rem_next_s;
  logic [SIZE_DATA-1:0]   data_shift_s;
  logic                   accept_s;

  assign o_ready     = (state_r == IDLE) & i_rst_n;
  assign accept_s    = i_valid & o_ready;
  assign o_valid     = (state_r == DONE);
  assign o_data      = data_r;
  assign o_exp       = exp_r;
  assign o_shift_amt = shift_amt_r;
  assign o_zero      = zero_r;
  assign o_underflow = underflow_r;

  // Shift amount and exponent adjustment for an incoming request.
  always_comb begin
    pos_s       = i_one_position;
    shift_eff_s = {SIZE_LOPD{1'b0}};
    exp_adj_s   = {SIZE_EXP{1'b0}};
    uf_s        = 1'b0;
    if (i_one_position > MAX_POS) begin
      pos_s = MAX_POS;
    end else begin
      pos_s = i_one_position;
    end
    shamt_s   = MAX_POS - pos_s;
    shamt_w_s = CW'(shamt_s);
    exp_w_s   = CW'(i_exp);
    if (shamt_w_s < exp_w_s) begin
      shift_eff_s = shamt_s;
      exp_adj_s   = i_exp - SIZE_EXP'(shamt_s);
      uf_s        = 1'b0;
    end else begin
      // Stop one short of the exponent so the result lands on the denormal encoding.
      exp_adj_s = {SIZE_EXP{1'b0}};
      uf_s      = 1'b1;
      if (i_exp == {SIZE_EXP{1'b0}}) begin
        shift_eff_s = {SIZE_LOPD{1'b0}};
      end else begin
        shift_eff_s = SIZE_LOPD'(exp_w_s - {{(CW-1){1'b0}}, 1'b1});
      end
    end
  end

  // One binary shift stage: the highest remaining amount bit is consumed each cycle.
  always_comb begin
    step_s = {SIZE_LOPD{1'b0}};
    for (int i = 0; i < SIZE_LOPD; i++) begin
      if (rem_r[i]) begin
        step_s = {{(SIZE_LOPD-1){1'b0}}, 1'b1} << i;
      end else begin
        step_s = step_s;
      end
    end
    rem_next_s   = rem_r & ~step_s;
    data_shift_s = data_r << step_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (i_zero_flag || (shift_eff_s == {SIZE_LOPD{1'b0}})) begin
            state_next_s = DONE;
          end else begin
            state_next_s = SHIFT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (rem_next_s == {SIZE_LOPD{1'b0}}) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers: capture on accept, shift in place while in SHIFT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r      <= {SIZE_DATA{1'b0}};
      exp_r       <= {SIZE_EXP{1'b0}};
      shift_amt_r <= {SIZE_LOPD{1'b0}};
      rem_r       <= {SIZE_LOPD{1'b0}};
      zero_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && i_zero_flag) begin
            data_r      <= {SIZE_DATA{1'b0}};
            exp_r       <= {SIZE_EXP{1'b0}};
            shift_amt_r <= {SIZE_LOPD{1'b0}};
            rem_r       <= {SIZE_LOPD{1'b0}};
            zero_r      <= 1'b1;
            underflow_r <= 1'b0;
          end else if (accept_s) begin
            data_r      <= i_data;
            exp_r       <= exp_adj_s;
            shift_amt_r <= shift_eff_s;
            rem_r       <= shift_eff_s;
            zero_r      <= 1'b0;
            underflow_r <= uf_s;
          end
        end
        SHIFT: begin
          data_r <= data_shift_s;
          rem_r  <= rem_next_s;
        end
        default: begin
          data_r <= data_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lopd_norm_shifter.sv
// Directed self-checking bench for lopd_norm_shifter: latency, exponent clamp, back-pressure and mid-flight reset.
module tb_lopd_norm_shifter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [23:0] i_data = 24'h0;
  logic [4:0]  i_one_position = 5'd0;
  logic        i_zero_flag = 1'b0;
  logic [7:0]  i_exp = 8'd0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [23:0] o_data;
  logic [7:0]  o_exp;
  logic [4:0]  o_shift_amt;
  logic        o_zero;
  logic        o_underflow;

  int checks_cnt = 0;
  int errors_cnt = 0;

  lopd_norm_shifter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_one_position(i_one_position), .i_zero_flag(i_zero_flag),
    .i_exp(i_exp), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_exp(o_exp), .o_shift_amt(o_shift_amt), .o_zero(o_zero), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive a request and let it be accepted at the next rising edge.
  task automatic send(input logic [23:0] d, input logic [4:0] pos, input logic z, input logic [7:0] e);
    @(negedge i_clk);
    i_data = d; i_one_position = pos; i_zero_flag = z; i_exp = e; i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Latency counted from the acceptance edge; bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input int lat, input int lat_exp,
                            input logic [23:0] d, input logic [7:0] e, input logic [4:0] sh,
                            input logic z, input logic uf);
    chk({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, ".lat"}, lat, lat_exp);
    chk({tag, ".data"}, {8'd0, o_data}, {8'd0, d});
    chk({tag, ".exp"}, {24'd0, o_exp}, {24'd0, e});
    chk({tag, ".shamt"}, {27'd0, o_shift_amt}, {27'd0, sh});
    chk({tag, ".zero"}, {31'd0, o_zero}, {31'd0, z});
    chk({tag, ".uf"}, {31'd0, o_underflow}, {31'd0, uf});
  endtask

  task automatic handshake(input string tag);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    chk({tag, ".drop"}, {31'd0, o_valid}, 32'd0);
    chk({tag, ".rdy"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    // Reset state
    #12;
    chk("rst.valid", {31'd0, o_valid}, 32'd0);
    chk("rst.data", {8'd0, o_data}, 32'd0);
    chk("rst.ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("idle.ready", {31'd0, o_ready}, 32'd1);

    send(24'h000001, 5'd0, 1'b0, 8'd100);
    wait_valid(lat);
    expect_res("c1", lat, 5, 24'h800000, 8'd77, 5'd23, 1'b0, 1'b0);
    handshake("c1");

    send(24'h800000, 5'd23, 1'b0, 8'd127);
    wait_valid(lat);
    expect_res("c2", lat, 1, 24'h800000, 8'd127, 5'd0, 1'b0, 1'b0);
    handshake("c2");

    send(24'h000000, 5'd0, 1'b1, 8'd50);
    wait_valid(lat);
    expect_res("c3", lat, 1, 24'h000000, 8'd0, 5'd0, 1'b1, 1'b0);
    handshake("c3");

    send(24'h000100, 5'd8, 1'b0, 8'd10);
    wait_valid(lat);
    expect_res("c4", lat, 3, 24'h020000, 8'd0, 5'd9, 1'b0, 1'b1);
    handshake("c4");

    // Illegal position clamps to shift 0
    send(24'h400000, 5'd31, 1'b0, 8'd5);
    wait_valid(lat);
    expect_res("ill", lat, 1, 24'h400000, 8'd5, 5'd0, 1'b0, 1'b0);
    handshake("ill");

    // Zero exponent: no shift, denormal
    send(24'h000010, 5'd4, 1'b0, 8'd0);
    wait_valid(lat);
    expect_res("e0", lat, 1, 24'h000010, 8'd0, 5'd0, 1'b0, 1'b1);
    handshake("e0");

    // shamt equal to exponent takes the clamp path
    send(24'h100000, 5'd20, 1'b0, 8'd3);
    wait_valid(lat);
    expect_res("eq", lat, 2, 24'h400000, 8'd0, 5'd2, 1'b0, 1'b1);
    handshake("eq");

    // Back-pressure in DONE with a new request waiting
    send(24'h000001, 5'd0, 1'b0, 8'd100);
    wait_valid(lat);
    i_data = 24'h800000; i_one_position = 5'd23; i_zero_flag = 1'b0; i_exp = 8'd127; i_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk);
      #1;
      expect_res("bp", lat, 5, 24'h800000, 8'd77, 5'd23, 1'b0, 1'b0);
      chk("bp.rdy", {31'd0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    chk("bp.drop", {31'd0, o_valid}, 32'd0);
    chk("bp.rdy1", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    wait_valid(lat);
    expect_res("bp2", lat, 1, 24'h800000, 8'd127, 5'd0, 1'b0, 1'b0);
    handshake("bp2");

    // Reset asserted mid-SHIFT
    send(24'h000001, 5'd0, 1'b0, 8'd100);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("mr.valid", {31'd0, o_valid}, 32'd0);
    chk("mr.data", {8'd0, o_data}, 32'd0);
    chk("mr.exp", {24'd0, o_exp}, 32'd0);
    chk("mr.shamt", {27'd0, o_shift_amt}, 32'd0);
    chk("mr.ready", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("mr.idle", {31'd0, o_ready}, 32'd1);
    send(24'h000100, 5'd8, 1'b0, 8'd10);
    wait_valid(lat);
    expect_res("mr4", lat, 3, 24'h020000, 8'd0, 5'd9, 1'b0, 1'b1);
    handshake("mr4");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
